// File: rtl/demux1t4_buf_if.sv
// demux1t4_buf_if: bundles the producer-side and consumer-side signals of the
// 1-to-4 buffered demultiplexer.
//   s         destination channel (0..3) of the current input beat
//   in_data   input payload
//   in_valid  producer has a beat
//   in_ready  selected channel can accept this cycle
//   out_data  channel k payload at [k*WIDTH +: WIDTH]
//   out_valid channel k has data at its head
//   out_ready consumer k accepts its head
//   count     channel k occupancy at [k*(AW+1) +: AW+1]
// master = producer/consumers (testbench side), slave = the demux itself.
interface demux1t4_buf_if #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 2
);
    localparam int AW = $clog2(DEPTH);

    logic [1:0]              s;
    logic [WIDTH-1:0]        in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [4*WIDTH-1:0]      out_data;
    logic [3:0]              out_valid;
    logic [3:0]              out_ready;
    logic [4*(AW+1)-1:0]     count;

    modport master (
        output s, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, count
    );

    modport slave (
        input  s, in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, count
    );
endinterface

// File: rtl/demux1t4_buf.sv
// demux1t4_buf: routes one WIDTH-bit stream into one of four channels chosen
// by bus.s. Each channel owns a DEPTH-entry FIFO with its own valid/ready
// handshake, so a stalled consumer only blocks its own channel.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (pointers and counts only)
//   bus    demux1t4_buf_if slave modport (see interface header)
module demux1t4_buf #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    demux1t4_buf_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [AW-1:0]    wr_ptr_q [4];
    logic [AW-1:0]    wr_ptr_d [4];
    logic [AW-1:0]    rd_ptr_q [4];
    logic [AW-1:0]    rd_ptr_d [4];
    logic [AW:0]      cnt_q    [4];
    logic [AW:0]      cnt_d    [4];
    logic [WIDTH-1:0] mem_q    [4][DEPTH];

    logic       in_ready;
    logic [3:0] push;
    logic [3:0] pop;

    // in_ready depends only on s and stored occupancy; a pop in the same
    // cycle never frees room for a push into a full channel.
    assign in_ready     = (cnt_q[bus.s] != FULL);
    assign bus.in_ready = in_ready;

    always_comb begin
        push          = '0;
        pop           = '0;
        bus.out_valid = '0;
        bus.out_data  = '0;
        bus.count     = '0;
        for (int k = 0; k < 4; k++) begin
            push[k] = bus.in_valid && in_ready && (bus.s == 2'(k));
            pop[k]  = (cnt_q[k] != '0) && bus.out_ready[k];

            wr_ptr_d[k] = wr_ptr_q[k] + AW'(push[k]);
            rd_ptr_d[k] = rd_ptr_q[k] + AW'(pop[k]);

            case ({push[k], pop[k]})
                2'b10:   cnt_d[k] = cnt_q[k] + 1'b1;
                2'b01:   cnt_d[k] = cnt_q[k] - 1'b1;
                default: cnt_d[k] = cnt_q[k];
            endcase

            bus.out_valid[k]                 = (cnt_q[k] != '0);
            bus.count[k*(AW+1) +: (AW+1)]    = cnt_q[k];
            // Empty channels present zero rather than stale storage.
            if (cnt_q[k] != '0) begin
                bus.out_data[k*WIDTH +: WIDTH] = mem_q[k][rd_ptr_q[k]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                cnt_q[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                wr_ptr_q[k] <= wr_ptr_d[k];
                rd_ptr_q[k] <= rd_ptr_d[k];
                cnt_q[k]    <= cnt_d[k];
            end
        end
    end

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (push[k]) begin
                mem_q[k][wr_ptr_q[k]] <= bus.in_data;
            end
        end
    end
endmodule
